wb_classic_traffic_master: RTL and testbench

- Synthesizable, parametrised Wishbone Classic bus master that generates scripted register traffic for bring-up and built-in self test of Wishbone peripherals, e.g. wishbone_classic_uart.
- Generalises a fixed write-only stimulus into configurable modes:
  - incrementing writes;
  - pattern-checking reads;
  - write-then-readback.
- Adds per-transaction timeout, address stride/wrap, and error accounting.
- Sits between a control source (CPU register file or test harness) and the Wishbone slave under exercise.

---
 rtl/wb_classic_traffic_master.sv | 191 +++++++++++++++++++
 tb/tb_wb_classic_traffic_master.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_classic_traffic_master.sv
// Wishbone Classic master that replays scripted register traffic (write, read-compare,
// write-readback, read-only) with a per-transaction ack timeout and mismatch accounting.
`timescale 1ns/1ps
module wb_classic_traffic_master #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int BUS_WIDTH      = 4,
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [ADDRESS_WIDTH-1:0]   base_addr,
    input  logic [ADDRESS_WIDTH-1:0]   addr_stride,
    input  logic [COUNT_WIDTH-1:0]     count,
    input  logic [BUS_WIDTH*8-1:0]     data_seed,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic [COUNT_WIDTH-1:0]     err_cnt,
    output logic [ADDRESS_WIDTH-1:0]   first_err_addr,
    output logic [BUS_WIDTH*8-1:0]     last_rdata,
    output logic                       m_wb_cyc,
    output logic                       m_wb_stb,
    output logic                       m_wb_we,
    output logic [ADDRESS_WIDTH-1:0]   m_wb_addr,
    output logic [BUS_WIDTH*8-1:0]     m_wb_data_o,
    output logic [BUS_WIDTH-1:0]       m_wb_sel,
    input  logic                       m_wb_ack,
    input  logic [BUS_WIDTH*8-1:0]     m_wb_data_i
);
    localparam int DW = BUS_WIDTH * 8;
    // The timer only ever holds 0..TIMEOUT_CYCLES-1; reaching the last value aborts.
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]               state_reg;
    logic [1:0]               mode_reg;
    logic [ADDRESS_WIDTH-1:0] stride_reg;
    logic [COUNT_WIDTH-1:0]   count_reg;
    logic [COUNT_WIDTH-1:0]   index_reg;
    logic [COUNT_WIDTH-1:0]   index_next;
    logic [TW-1:0]            timer_reg;
    logic                     last_wr_reg;
    logic                     busy_reg;
    logic                     done_reg;
    logic                     timeout_reg;
    logic [COUNT_WIDTH-1:0]   err_cnt_reg;
    logic [ADDRESS_WIDTH-1:0] first_err_addr_reg;
    logic [DW-1:0]            last_rdata_reg;
    logic                     cyc_reg;
    logic                     stb_reg;
    logic                     we_reg;
    logic [ADDRESS_WIDTH-1:0] addr_reg;
    logic [DW-1:0]            data_reg;
    logic                     compare_mode;

    assign index_next   = index_reg + 1'b1;
    assign compare_mode = (mode_reg == 2'd1) || (mode_reg == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= S_IDLE;
            mode_reg           <= '0;
            stride_reg         <= '0;
            count_reg          <= '0;
            index_reg          <= '0;
            timer_reg          <= '0;
            last_wr_reg        <= 1'b0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
            timeout_reg        <= 1'b0;
            err_cnt_reg        <= '0;
            first_err_addr_reg <= '0;
            last_rdata_reg     <= '0;
            cyc_reg            <= 1'b0;
            stb_reg            <= 1'b0;
            we_reg             <= 1'b0;
            addr_reg           <= '0;
            data_reg           <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        mode_reg           <= mode;
                        stride_reg         <= addr_stride;
                        count_reg          <= count;
                        index_reg          <= '0;
                        addr_reg           <= base_addr;
                        data_reg           <= data_seed;
                        err_cnt_reg        <= '0;
                        first_err_addr_reg <= '0;
                        timeout_reg        <= 1'b0;
                        timer_reg          <= '0;
                        if (count == '0) begin
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            busy_reg  <= 1'b1;
                            cyc_reg   <= 1'b1;
                            stb_reg   <= 1'b1;
                            we_reg    <= ~mode[0];
                            state_reg <= mode[0] ? S_RD : S_WR;
                        end
                    end
                end
                S_WR, S_RD: begin
                    if (stb_reg && m_wb_ack) begin
                        cyc_reg     <= 1'b0;
                        stb_reg     <= 1'b0;
                        we_reg      <= 1'b0;
                        last_wr_reg <= (state_reg == S_WR);
                        state_reg   <= S_GAP;
                        if (state_reg == S_RD) begin
                            last_rdata_reg <= m_wb_data_i;
                            if (compare_mode && (m_wb_data_i != data_reg)) begin
                                if (err_cnt_reg == '0)
                                    first_err_addr_reg <= addr_reg;
                                if (err_cnt_reg != '1)
                                    err_cnt_reg <= err_cnt_reg + 1'b1;
                            end
                        end
                    end else if (timer_reg == TIMER_LAST) begin
                        // Abort the whole run: no further indices are attempted.
                        cyc_reg     <= 1'b0;
                        stb_reg     <= 1'b0;
                        we_reg      <= 1'b0;
                        timeout_reg <= 1'b1;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        state_reg   <= S_DONE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                S_GAP: begin
                    timer_reg <= '0;
                    if (mode_reg == 2'd2 && last_wr_reg) begin
                        cyc_reg   <= 1'b1;
                        stb_reg   <= 1'b1;
                        we_reg    <= 1'b0;
                        state_reg <= S_RD;
                    end else if (index_next == count_reg) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        index_reg <= index_next;
                        addr_reg  <= addr_reg + stride_reg;
                        data_reg  <= data_reg + 1'b1;
                        cyc_reg   <= 1'b1;
                        stb_reg   <= 1'b1;
                        we_reg    <= ~mode_reg[0];
                        state_reg <= mode_reg[0] ? S_RD : S_WR;
                    end
                end
                S_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BUS_WIDTH; gi++) begin : g_sel
            assign m_wb_sel[gi] = stb_reg;
        end
    endgenerate

    assign busy           = busy_reg;
    assign done           = done_reg;
    assign timeout        = timeout_reg;
    assign err_cnt        = err_cnt_reg;
    assign first_err_addr = first_err_addr_reg;
    assign last_rdata     = last_rdata_reg;
    assign m_wb_cyc       = cyc_reg;
    assign m_wb_stb       = stb_reg;
    assign m_wb_we        = we_reg;
    assign m_wb_addr      = addr_reg;
    assign m_wb_data_o    = data_reg;
endmodule

// File: tb/tb_wb_classic_traffic_master.sv
// Bench for wb_classic_traffic_master: memory slave with random ack latency, a transaction
// log, and a reference model that predicts each run from the traffic rules directly.
`timescale 1ns/1ps
module tb_wb_classic_traffic_master;
    localparam int AW = 16;
    localparam int BW = 4;
    localparam int CW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = '0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] addr_stride = '0;
    logic [CW-1:0] count = '0;
    logic [31:0]   data_seed = '0;
    logic          busy, done, timeout;
    logic [CW-1:0] err_cnt;
    logic [AW-1:0] first_err_addr;
    logic [31:0]   last_rdata;
    logic          m_wb_cyc, m_wb_stb, m_wb_we;
    logic [AW-1:0] m_wb_addr;
    logic [31:0]   m_wb_data_o;
    logic [BW-1:0] m_wb_sel;
    logic          m_wb_ack = 1'b0;
    logic [31:0]   m_wb_data_i = '0;

    wb_classic_traffic_master #(
        .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
        .addr_stride(addr_stride), .count(count), .data_seed(data_seed),
        .busy(busy), .done(done), .timeout(timeout), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr), .last_rdata(last_rdata),
        .m_wb_cyc(m_wb_cyc), .m_wb_stb(m_wb_stb), .m_wb_we(m_wb_we), .m_wb_addr(m_wb_addr),
        .m_wb_data_o(m_wb_data_o), .m_wb_sel(m_wb_sel), .m_wb_ack(m_wb_ack),
        .m_wb_data_i(m_wb_data_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        obs_q[$];
    logic [31:0] mem [0:65535];
    int          n_assert = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          stb_cycles = 0;
    int          gap = 0;
    bit          seen_tx = 0;
    bit          prev_cyc = 0;
    bit          noack = 0;
    bit          stray_en = 0;
    bit          cor_en = 0;
    logic [15:0] cor_a = '0;
    int          max_lat = 0;
    int          wait_cnt = 0;
    int          lat = 0;
    logic [31:0] model_last_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave: acks after a random latency, logs each accepted transaction, may inject stray acks.
    always @(negedge clk) begin
        txn_t t;
        if (rst || !m_wb_stb) begin
            wait_cnt = 0;
            lat = $urandom_range(0, max_lat);
            m_wb_ack = !rst && stray_en && ($urandom_range(0, 3) == 0);
            m_wb_data_i = $urandom;
        end else if (noack) begin
            m_wb_ack = 1'b0;
        end else if (wait_cnt >= lat) begin
            t.we = m_wb_we;
            t.addr = m_wb_addr;
            if (m_wb_we) begin
                t.data = m_wb_data_o;
                mem[m_wb_addr] = m_wb_data_o;
                m_wb_data_i = $urandom;
            end else begin
                t.data = (cor_en && m_wb_addr == cor_a) ? 32'hDEADBEEF : mem[m_wb_addr];
                m_wb_data_i = t.data;
            end
            obs_q.push_back(t);
            m_wb_ack = 1'b1;
        end else begin
            m_wb_ack = 1'b0;
            wait_cnt++;
        end
    end

    // Protocol monitor: cyc/stb together, sel all ones, exactly one idle cycle between transfers.
    always @(negedge clk) begin
        if (rst) begin
            seen_tx = 0;
            gap = 0;
            prev_cyc = 0;
        end else begin
            if (m_wb_stb) stb_cycles++;
            if (done) done_cnt++;
            chk("cyc_eq_stb", 64'(m_wb_cyc), 64'(m_wb_stb));
            if (m_wb_stb) chk("sel_ones", 64'(m_wb_sel), 64'hF);
            if (!busy) begin
                seen_tx = 0;
                gap = 0;
            end else if (m_wb_cyc) begin
                if (!prev_cyc && seen_tx) chk("gap_len", 64'(gap), 64'd1);
                seen_tx = 1;
                gap = 0;
            end else begin
                gap++;
            end
            prev_cyc = m_wb_cyc;
        end
    end

    task automatic run(input logic [1:0] md, input logic [15:0] b, input logic [15:0] s,
                       input logic [15:0] c, input logic [31:0] sd);
        txn_t        exp_q[$];
        txn_t        t;
        logic [31:0] sh [logic [15:0]];
        logic [15:0] a;
        logic [31:0] d, rv;
        int          e_err = 0;
        logic [15:0] e_first = '0;
        int          dn0;
        bit          got = 0;
        if (md[0]) begin
            for (int i = 0; i < int'(c); i++) begin
                a = b + 16'(i) * s;
                mem[a] = ($urandom_range(0, 1) == 1) ? sd + 32'(i) : $urandom;
            end
        end
        for (int i = 0; i < int'(c); i++) begin
            a = b + 16'(i) * s;
            d = sd + 32'(i);
            if (md == 2'd0 || md == 2'd2) begin
                t.we = 1'b1; t.addr = a; t.data = d;
                exp_q.push_back(t);
                sh[a] = d;
            end
            if (md != 2'd0) begin
                if (cor_en && a == cor_a) rv = 32'hDEADBEEF;
                else if (sh.exists(a)) rv = sh[a];
                else rv = mem[a];
                t.we = 1'b0; t.addr = a; t.data = rv;
                exp_q.push_back(t);
                model_last_rdata = rv;
                if (md != 2'd3 && rv != d) begin
                    if (e_err == 0) e_first = a;
                    e_err++;
                end
            end
        end
        @(negedge clk);
        mode = md; base_addr = b; addr_stride = s; count = c; data_seed = sd; start = 1'b1;
        obs_q.delete();
        stb_cycles = 0;
        dn0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        mode = 2'($urandom); base_addr = 16'($urandom); addr_stride = 16'($urandom);
        count = 16'($urandom); data_seed = $urandom;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("cyc_after_start", 64'(m_wb_cyc), 64'd1);
        chk("timeout_cleared", 64'(timeout), 64'd0);
        chk("err_cleared", 64'(err_cnt), 64'd0);
        chk("first_err_cleared", 64'(first_err_addr), 64'd0);
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1;
            else start = ($urandom_range(0, 7) == 0);
        end
        start = 1'b0;
        chk("done_reached", 64'(got), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("err_cnt", 64'(err_cnt), 64'(e_err));
        chk("first_err_addr", 64'(first_err_addr), 64'(e_first));
        chk("last_rdata", 64'(last_rdata), 64'(model_last_rdata));
        chk("timeout_flag", 64'(timeout), 64'd0);
        chk("txn_count", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("txn%0d", i), 64'(obs_q[i]), 64'(exp_q[i]));
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("done_pulses", 64'(done_cnt - dn0), 64'd1);
        chk("idle_after_run", 64'(busy), 64'd0);
    endtask

    initial begin
        int dn0;
        bit got;
        logic [31:0] sd;
        logic [15:0] b, s, c;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cyc", 64'(m_wb_cyc), 64'd0);
        chk("rst_stb", 64'(m_wb_stb), 64'd0);
        chk("rst_we", 64'(m_wb_we), 64'd0);
        chk("rst_addr", 64'(m_wb_addr), 64'd0);
        chk("rst_data_o", 64'(m_wb_data_o), 64'd0);
        chk("rst_err", 64'(err_cnt), 64'd0);
        chk("rst_last_rdata", 64'(last_rdata), 64'd0);
        rst = 1'b0;

        // Incrementing writes with single-cycle ack.
        max_lat = 0;
        run(2'd0, 16'h0004, 16'h0004, 16'd3, 32'hAAAA0000);
        chk("tp_w0", 64'(obs_q[0]), {15'd0, 1'b1, 16'h0004, 32'hAAAA0000});
        chk("tp_w1", 64'(obs_q[1]), {15'd0, 1'b1, 16'h0008, 32'hAAAA0001});
        chk("tp_w2", 64'(obs_q[2]), {15'd0, 1'b1, 16'h000C, 32'hAAAA0002});

        // Write-readback with one corrupted read.
        max_lat = 2;
        cor_en = 1; cor_a = 16'h0008;
        sd = $urandom;
        run(2'd2, 16'h0000, 16'h0004, 16'd4, sd);
        chk("tp_rb_err", 64'(err_cnt), 64'd1);
        chk("tp_rb_first", 64'(first_err_addr), 64'h8);
        chk("tp_rb_last", 64'(last_rdata), 64'(sd + 32'd3));
        cor_en = 0;

        // No ack: abort after TO strobe cycles.
        noack = 1;
        @(negedge clk);
        mode = 2'd1; base_addr = 16'h0100; addr_stride = 16'h4; count = 16'd3; start = 1'b1;
        obs_q.delete(); stb_cycles = 0; dn0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        chk("to_done_reached", 64'(got), 64'd1);
        chk("to_flag", 64'(timeout), 64'd1);
        chk("to_busy", 64'(busy), 64'd0);
        chk("to_cyc", 64'(m_wb_cyc), 64'd0);
        chk("to_stb_cycles", 64'(stb_cycles), 64'(TO));
        chk("to_no_txn", 64'(obs_q.size()), 64'd0);
        @(negedge clk);
        chk("to_done_pulses", 64'(done_cnt - dn0), 64'd1);
        chk("to_sticky", 64'(timeout), 64'd1);
        noack = 0;

        // count == 0: immediate done, no bus activity.
        @(negedge clk);
        count = 16'd0; mode = 2'd0; start = 1'b1; stb_cycles = 0;
        @(negedge clk);
        start = 1'b0;
        chk("c0_done", 64'(done), 64'd1);
        chk("c0_cyc", 64'(m_wb_cyc), 64'd0);
        chk("c0_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("c0_done_low", 64'(done), 64'd0);
        chk("c0_no_stb", 64'(stb_cycles), 64'd0);

        // Address wrap at the top of the address space.
        max_lat = 1;
        run(2'd0, 16'hFFF8, 16'h0004, 16'd4, $urandom);
        chk("wrap_a0", 64'(obs_q[0].addr), 64'hFFF8);
        chk("wrap_a1", 64'(obs_q[1].addr), 64'hFFFC);
        chk("wrap_a2", 64'(obs_q[2].addr), 64'h0000);
        chk("wrap_a3", 64'(obs_q[3].addr), 64'h0004);

        // Reset while a strobe waits for ack.
        noack = 1;
        @(negedge clk);
        mode = 2'd0; base_addr = 16'h0040; addr_stride = 16'h4; count = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstmid_stb_before", 64'(m_wb_stb), 64'd1);
        dn0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_cyc", 64'(m_wb_cyc), 64'd0);
        chk("rstmid_stb", 64'(m_wb_stb), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_done", 64'(done), 64'd0);
        chk("rstmid_last_rdata", 64'(last_rdata), 64'd0);
        rst = 1'b0;
        noack = 0;
        model_last_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rstmid_no_done", 64'(done_cnt - dn0), 64'd0);
        run(2'd1, 16'h0200, 16'h0004, 16'd3, $urandom);

        // Randomised runs with stray acks and occasional corruption.
        for (int r = 0; r < 30; r++) begin
            b = 16'($urandom);
            s = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(4 * $urandom_range(0, 4));
            c = 16'($urandom_range(1, 6));
            max_lat = $urandom_range(0, 3);
            stray_en = $urandom_range(0, 1);
            cor_en = $urandom_range(0, 1);
            cor_a = b + 16'($urandom_range(0, int'(c) - 1)) * s;
            run(2'($urandom), b, s, c, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
